// File: rtl/uart_receiver_param.sv
// Oversampling UART receiver: LSB-first frames, optional parity, 1 or 2 stop bits.
// Reports data with a one-clock valid pulse plus parity, framing and break flags.
module uart_receiver_param #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  baud_clk_os,
    input  logic                  Rx_in,
    output logic [DATA_WIDTH-1:0] data_bus,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  break_detect,
    output logic                  busy
);

    localparam int TW = $clog2(OVERSAMPLE) + 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE} state_t;

    state_t                  state, state_nxt;
    logic                    rx_p0, rx_p1;
    logic                    baud_p0, baud_p1, baud_p2;
    logic [TW-1:0]           tick_cnt, tick_nxt, tick_adv;
    logic [BW-1:0]           bit_cnt, bit_nxt;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_nxt;
    logic                    par_acc, par_acc_nxt;
    logic                    par_bit, par_bit_nxt;
    logic                    perr, perr_nxt;
    logic                    ferr, ferr_nxt;
    logic                    rx, tick, sample;

    assign rx     = rx_p1;
    assign tick   = baud_p1 & ~baud_p2;
    assign sample = tick && (tick_cnt == BIT_LAST);
    // Bit-period counter shared by the data, parity and stop phases
    assign tick_adv = !tick ? tick_cnt : (sample ? '0 : tick_cnt + 1'b1);
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        tick_nxt    = tick_cnt;
        bit_nxt     = bit_cnt;
        shift_nxt   = shift_reg;
        par_acc_nxt = par_acc;
        par_bit_nxt = par_bit;
        perr_nxt    = perr;
        ferr_nxt    = ferr;
        case (state)
            IDLE: begin
                tick_nxt = '0;
                if (!rx) state_nxt = START;
            end
            START: begin
                if (tick) begin
                    if (rx) begin
                        state_nxt = IDLE;
                    end else if (tick_cnt == HALF_LAST) begin
                        state_nxt   = DATA;
                        tick_nxt    = '0;
                        bit_nxt     = '0;
                        par_acc_nxt = 1'b0;
                        par_bit_nxt = 1'b0;
                        perr_nxt    = 1'b0;
                        ferr_nxt    = 1'b0;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                tick_nxt = tick_adv;
                if (sample) begin
                    shift_nxt   = {rx, shift_reg[DATA_WIDTH-1:1]};
                    par_acc_nxt = par_acc ^ rx;
                    bit_nxt     = bit_cnt + 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                tick_nxt = tick_adv;
                if (sample) begin
                    par_bit_nxt = rx;
                    perr_nxt    = ((par_acc ^ rx) != ODD);
                    state_nxt   = STOP;
                end
            end
            STOP: begin
                tick_nxt = tick_adv;
                if (sample) begin
                    if (!rx) ferr_nxt = 1'b1;
                    if (bit_cnt == STOP_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            // A line still low here is a break or bad stop; wait for idle before rearming
            DONE:      state_nxt = rx ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx_p0         <= 1'b1;
            rx_p1         <= 1'b1;
            baud_p0       <= 1'b0;
            baud_p1       <= 1'b0;
            baud_p2       <= 1'b0;
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            par_acc       <= 1'b0;
            par_bit       <= 1'b0;
            perr          <= 1'b0;
            ferr          <= 1'b0;
            data_bus      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            break_detect  <= 1'b0;
        end else begin
            rx_p0      <= Rx_in;
            rx_p1      <= rx_p0;
            baud_p0    <= baud_clk_os;
            baud_p1    <= baud_p0;
            baud_p2    <= baud_p1;
            state      <= state_nxt;
            tick_cnt   <= tick_nxt;
            bit_cnt    <= bit_nxt;
            shift_reg  <= shift_nxt;
            par_acc    <= par_acc_nxt;
            par_bit    <= par_bit_nxt;
            perr       <= perr_nxt;
            ferr       <= ferr_nxt;
            data_valid <= (state == DONE);
            if (state == DONE) begin
                data_bus      <= shift_reg;
                parity_error  <= perr;
                framing_error <= ferr;
                break_detect  <= ferr && (shift_reg == '0) && ((PARITY_EN == 0) || !par_bit);
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver_param.sv
// Bench for uart_receiver_param: three instances (8N1, 8E1, 8N2) driven by serial
// frames and compared against a frame-level model of the expected word and flags.
module tb_uart_receiver_param;

    localparam int OS  = 8;
    localparam int BIT = OS * 20;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } rec_t;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic baud = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic [7:0] data_a, data_b, data_c;
    logic dv_a, pe_a, fe_a, bk_a, busy_a;
    logic dv_b, pe_b, fe_b, bk_b, busy_b;
    logic dv_c, pe_c, fe_c, bk_c, busy_c;

    rec_t q_a[$], q_b[$], q_c[$];
    int pulses_a = 0;
    int n_checks = 0;
    int n_fail = 0;

    uart_receiver_param #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clock(clock), .resetn(resetn), .baud_clk_os(baud), .Rx_in(rx_a),
        .data_bus(data_a), .data_valid(dv_a), .parity_error(pe_a),
        .framing_error(fe_a), .break_detect(bk_a), .busy(busy_a));

    uart_receiver_param #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
        .clock(clock), .resetn(resetn), .baud_clk_os(baud), .Rx_in(rx_b),
        .data_bus(data_b), .data_valid(dv_b), .parity_error(pe_b),
        .framing_error(fe_b), .break_detect(bk_b), .busy(busy_b));

    uart_receiver_param #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_c (
        .clock(clock), .resetn(resetn), .baud_clk_os(baud), .Rx_in(rx_c),
        .data_bus(data_c), .data_valid(dv_c), .parity_error(pe_c),
        .framing_error(fe_c), .break_detect(bk_c), .busy(busy_c));

    always #5 clock = ~clock;

    // Oversample clock: one tick every two system clocks, edges offset from the clock
    initial begin
        #2;
        forever begin
            #10 baud = ~baud;
        end
    end

    always @(negedge clock) begin
        if (dv_a === 1'b1) begin
            q_a.push_back(rec_t'({data_a, pe_a, fe_a, bk_a}));
            pulses_a++;
        end
        if (dv_b === 1'b1) q_b.push_back(rec_t'({data_b, pe_b, fe_b, bk_b}));
        if (dv_c === 1'b1) q_c.push_back(rec_t'({data_c, pe_c, fe_c, bk_c}));
    end

    // Expected outcome of one frame; line 0 = 8N1, 1 = 8E1, 2 = 8N2
    function automatic rec_t model(input int line, input logic [7:0] d, input logic pbit, input logic [1:0] stops);
        rec_t r;
        logic ferr;
        logic has_par;
        has_par = (line == 1);
        ferr = (stops[0] == 1'b0) || (line == 2 && stops[1] == 1'b0);
        r.d  = d;
        r.pe = has_par && ((($countones(d) + int'(pbit)) % 2) != 0);
        r.fe = ferr;
        r.bk = ferr && (d == 8'h00) && !(has_par && pbit);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int line, input logic v);
        case (line)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic send(input int line, input logic [7:0] d, input logic pbit, input logic [1:0] stops);
        drive(line, 1'b0);
        #BIT;
        for (int i = 0; i < 8; i++) begin
            drive(line, d[i]);
            #BIT;
        end
        if (line == 1) begin
            drive(line, pbit);
            #BIT;
        end
        drive(line, stops[0]);
        #BIT;
        if (line == 2) begin
            drive(line, stops[1]);
            #BIT;
        end
        drive(line, 1'b1);
    endtask

    task automatic expect_frame(input int line, input string tag, input rec_t exp);
        rec_t got;
        int n;
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            case (line)
                0:       n = q_a.size();
                1:       n = q_b.size();
                default: n = q_c.size();
            endcase
            if (n != 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk({tag, "_arrived"}, {31'd0, ok}, 32'd1);
        if (ok) begin
            case (line)
                0:       got = q_a.pop_front();
                1:       got = q_b.pop_front();
                default: got = q_c.pop_front();
            endcase
            chk({tag, "_data"}, {24'd0, got.d}, {24'd0, exp.d});
            chk({tag, "_perr"}, {31'd0, got.pe}, {31'd0, exp.pe});
            chk({tag, "_ferr"}, {31'd0, got.fe}, {31'd0, exp.fe});
            chk({tag, "_brk"},  {31'd0, got.bk}, {31'd0, exp.bk});
        end
    endtask

    task automatic send_and_check(input int line, input string tag, input logic [7:0] d, input logic pbit, input logic [1:0] stops);
        send(line, d, pbit, stops);
        expect_frame(line, tag, model(line, d, pbit, stops));
    endtask

    initial begin
        int p0;
        logic [7:0] d;
        logic pb;
        logic [1:0] st;

        repeat (3) @(negedge clock);
        chk("rst_data",  {24'd0, data_a}, 32'd0);
        chk("rst_valid", {31'd0, dv_a}, 32'd0);
        chk("rst_perr",  {31'd0, pe_a}, 32'd0);
        chk("rst_ferr",  {31'd0, fe_a}, 32'd0);
        chk("rst_brk",   {31'd0, bk_a}, 32'd0);
        chk("rst_busy",  {29'd0, busy_a, busy_b, busy_c}, 32'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clock);

        p0 = pulses_a;
        send_and_check(0, "a5", 8'hA5, 1'b0, 2'b11);
        #BIT;
        chk("a5_one_pulse", pulses_a - p0, 32'd1);

        p0 = pulses_a;
        drive(0, 1'b0);
        #40;
        drive(0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (busy_a === 1'b0) break;
        end
        chk("glitch_busy", {31'd0, busy_a}, 32'd0);
        #(12 * BIT);
        chk("glitch_no_valid", pulses_a - p0, 32'd0);

        send_and_check(1, "par_ok", 8'h03, 1'b0, 2'b11);
        send_and_check(1, "par_bad", 8'h03, 1'b1, 2'b11);

        send_and_check(2, "stop2_low", 8'h5A, 1'b0, 2'b01);
        #(2 * BIT);

        p0 = pulses_a;
        drive(0, 1'b0);
        #(30 * BIT);
        chk("break_one_pulse", pulses_a - p0, 32'd1);
        expect_frame(0, "break", model(0, 8'h00, 1'b0, 2'b00));
        chk("break_busy_held", {31'd0, busy_a}, 32'd1);
        drive(0, 1'b1);
        #(2 * BIT);
        send_and_check(0, "after_break", 8'h7E, 1'b0, 2'b11);
        #(2 * BIT);

        p0 = pulses_a;
        send(0, 8'h00, 1'b0, 2'b11);
        send(0, 8'hFF, 1'b0, 2'b11);
        send(0, 8'h81, 1'b0, 2'b11);
        drive(0, 1'b0);
        #BIT;
        drive(0, 1'b0);
        #BIT;
        drive(0, 1'b1);
        #(BIT / 2);
        resetn = 1'b0;
        #1;
        chk("midrst_data",  {24'd0, data_a}, 32'd0);
        chk("midrst_busy",  {31'd0, busy_a}, 32'd0);
        chk("midrst_flags", {28'd0, dv_a, pe_a, fe_a, bk_a}, 32'd0);
        @(negedge clock);
        drive(0, 1'b1);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        chk("b2b_pulses", pulses_a - p0, 32'd3);
        expect_frame(0, "b2b_00", model(0, 8'h00, 1'b0, 2'b11));
        expect_frame(0, "b2b_ff", model(0, 8'hFF, 1'b0, 2'b11));
        expect_frame(0, "b2b_81", model(0, 8'h81, 1'b0, 2'b11));
        #(2 * BIT);
        send_and_check(0, "post_rst", 8'h3C, 1'b0, 2'b11);

        for (int it = 0; it < 6; it++) begin
            #(2 * BIT);
            d = 8'($urandom);
            if ($urandom_range(0, 4) == 0) d = 8'h00;
            send_and_check(0, "rnd_a", d, 1'b0, 2'b11);
            #(2 * BIT);
            d = 8'($urandom);
            pb = 1'($urandom_range(0, 1));
            send_and_check(1, "rnd_b", d, pb, 2'b11);
            #(2 * BIT);
            d = 8'($urandom);
            if ($urandom_range(0, 4) == 0) d = 8'h00;
            st = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            send_and_check(2, "rnd_c", d, 1'b0, st);
        end

        #(4 * BIT);
        chk("qa_empty", q_a.size(), 32'd0);
        chk("qb_empty", q_b.size(), 32'd0);
        chk("qc_empty", q_c.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver_param.md
Name: uart_receiver_param

Overview:
Parametrised next-generation UART receiver. Oversamples a serial line using an externally supplied oversample clock (level signal, rising-edge detected in the system clock domain). Deserialises configurable-width LSB-first frames with optional parity and 1 or 2 stop bits. Presents the data word with a one-cycle valid strobe and per-frame error flags (parity, framing, break); sits between the pin-level Rx line and the host-side data consumer.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..32
OVERSAMPLE, 8, oversample ticks per bit; even, legal 4..16
PARITY_EN, 0, 1 = parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits checked; legal 1 or 2

Ports:
clock  in  1  system clock; all logic on its rising edge
resetn  in  1  asynchronous active-low reset
baud_clk_os  in  1  oversample clock, OVERSAMPLE x baud, asynchronous level
Rx_in  in  1  serial input, idle high, asynchronous
data_bus  out  DATA_WIDTH  last received word, held until the next frame completes
data_valid  out  1  one-clock pulse, frame complete
parity_error  out  1  parity mismatch for the frame; valid with data_valid, held until the next frame
framing_error  out  1  a stop bit sampled low; valid with data_valid, held
break_detect  out  1  break condition; valid with data_valid, held
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async assert, any state): FSM to IDLE; all outputs 0; synchronisers reset to 1 (Rx) and 0 (baud clock); counters 0. Release is synchronous to clock.
- Rx_in passes a 2-flop synchroniser; baud_clk_os passes a 2-flop synchroniser plus a previous-value flop. tick = sync & ~prev, one clock wide. Internal Rx latency is 2 clocks.
- tick_cnt counts ticks (width clog2(OVERSAMPLE)+1); bit_cnt counts data bits.
- IDLE: on synced Rx = 0, go to START with tick_cnt = 0.
- START: each tick samples Rx. If Rx = 1, return to IDLE (glitch reject). When tick_cnt reaches OVERSAMPLE/2 - 1 with Rx still 0, the start bit is confirmed (mid-bit); go to DATA with tick_cnt = 0 and bit_cnt = 0.
- DATA: sample Rx on the tick where tick_cnt = OVERSAMPLE-1, then clear tick_cnt. Shift LSB-first into shift_reg[DATA_WIDTH-1:0] and XOR the bit into par_acc. After DATA_WIDTH samples, go to PARITY if PARITY_EN, else STOP.
- PARITY: one bit, same timing. perr = (par_acc ^ bit) != PARITY_ODD. That is, even parity requires an even count of ones across data plus parity bit.
- STOP: STOP_BITS samples, same timing. Any stop sample = 0 sets ferr. After the last stop sample go to DONE.
- DONE (1 clock): data_bus <= shift_reg; parity_error <= perr; framing_error <= ferr; break_detect <= ferr & (shift_reg == 0) & (parity bit == 0 or PARITY_EN = 0). data_valid = 1 for this one clock. Next state is IDLE if synced Rx = 1; otherwise WAIT_IDLE.
- WAIT_IDLE: stay until synced Rx = 1, then IDLE. This covers break and framing faults, and prevents a held-low line from being seen as a new start.
- Latency: data_valid rises 1 clock after the clock on which the final stop-bit tick is processed.
- Data and flags are always delivered, even on error. The consumer qualifies them with the error flags.
- A new frame's start bit arriving while in DONE is detected on the next IDLE cycle. Data is lost only if the line violates stop-bit timing.
- Simultaneous tick and Rx edge: the synchronised Rx value registered that clock is used; no special case.
- Back-to-back frames with exactly STOP_BITS stop bits must be received without loss.
- busy = 0 only in IDLE.

Test Plan:
- DATA_WIDTH=8, OVERSAMPLE=8, no parity: send 0xA5 (8N1) -> data_bus=0xA5, one data_valid pulse, all error flags 0.
- Glitch: Rx low for 2 ticks, then high -> no data_valid; FSM back to IDLE; busy drops within 5 clocks of Rx returning high.
- PARITY_EN=1, even: send 0x03 with parity 0 -> parity_error=0; resend with parity 1 -> parity_error=1 and data_bus=0x03.
- STOP_BITS=2: second stop bit driven low on 0x5A -> framing_error=1, break_detect=0, data_bus=0x5A.
- Break: Rx held low for 3 frame times -> exactly one data_valid with break_detect=1 and data_bus=0; no further frames until Rx returns high; then 0x7E is received cleanly with flags cleared.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap, then resetn pulsed low mid-frame on a fourth byte -> three valid pulses with correct data; outputs 0 immediately on reset; the next full frame is received correctly.
